// File: rtl/tinytpu_serial_host.sv
// Host side of the tinytpu bit-serial link: serialises two operand matrices,
// pulses init, then deserialises the returned result matrix.
module tinytpu_serial_host #(
    parameter int D_W     = 8,
    parameter int N       = 2,
    parameter int OUT_W   = 17,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*N*D_W-1:0]     x_mat,
    input  logic [N*N*D_W-1:0]     y_mat,
    output logic                   busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic [N*N*OUT_W-1:0]   z_mat,
    output logic                   data_in_x,
    output logic                   data_in_y,
    output logic                   load_en,
    output logic                   init,
    input  logic                   data_out_z,
    input  logic                   tx_ready
);

    localparam int L   = N * N * D_W;
    localparam int R   = N * N * OUT_W;
    localparam int LCW = (L > 1) ? $clog2(L) : 1;
    localparam int RCW = (R > 1) ? $clog2(R) : 1;
    localparam int SCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, WAIT, RECV, DONE} state_t;

    state_t           state;
    logic [LCW-1:0]   bit_cnt;
    logic [RCW-1:0]   rx_cnt;
    logic [SCW-1:0]   stall_cnt;
    logic [L-1:0]     x_sh, y_sh;
    logic [L-1:0]     x_ser, y_ser;
    logic [R-1:0]     rx_sh;
    logic [R-1:0]     rx_next;
    logic [R-1:0]     z_next;

    // Element order is reversed so the shift registers always emit their MSB;
    // bits within an element already sit MSB first.
    for (genvar e = 0; e < N * N; e++) begin : g_elem
        assign x_ser[(N*N-1-e)*D_W +: D_W]     = x_mat[e*D_W +: D_W];
        assign y_ser[(N*N-1-e)*D_W +: D_W]     = y_mat[e*D_W +: D_W];
        assign z_next[e*OUT_W +: OUT_W]        = rx_next[(N*N-1-e)*OUT_W +: OUT_W];
    end

    assign rx_next = {rx_sh[R-2:0], data_out_z};

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            x_sh <= {x_ser[L-2:0], 1'b0};
            y_sh <= {y_ser[L-2:0], 1'b0};
        end else if (state == LOAD) begin
            x_sh <= {x_sh[L-2:0], 1'b0};
            y_sh <= {y_sh[L-2:0], 1'b0};
        end
        if ((state == WAIT || state == RECV) && tx_ready) begin
            rx_sh <= rx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            z_mat       <= '0;
            data_in_x   <= 1'b0;
            data_in_y   <= 1'b0;
            load_en     <= 1'b0;
            init        <= 1'b0;
            bit_cnt     <= '0;
            rx_cnt      <= '0;
            stall_cnt   <= '0;
        end else begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            init        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        load_en   <= 1'b1;
                        data_in_x <= x_ser[L-1];
                        data_in_y <= y_ser[L-1];
                        bit_cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (bit_cnt == LCW'(L - 1)) begin
                        state     <= INIT;
                        load_en   <= 1'b0;
                        data_in_x <= 1'b0;
                        data_in_y <= 1'b0;
                        init      <= 1'b1;
                    end else begin
                        data_in_x <= x_sh[L-1];
                        data_in_y <= y_sh[L-1];
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                INIT: begin
                    state     <= WAIT;
                    rx_cnt    <= '0;
                    stall_cnt <= '0;
                end
                WAIT, RECV: begin
                    if (tx_ready) begin
                        stall_cnt <= '0;
                        if (rx_cnt == RCW'(R - 1)) begin
                            state <= DONE;
                            z_mat <= z_next;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state  <= RECV;
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end else if (stall_cnt == SCW'(TIMEOUT - 1)) begin
                        // Abandon the transaction; z_mat keeps the last good result.
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
